// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall/bubble control beside the ID/EX register.
// Optional statistics counters are built only when FWD_STAT_EN is defined.
module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              idValidIn,
    input  logic [REG_AW-1:0] idRs1In,
    input  logic [REG_AW-1:0] idRs2In,
    input  logic [REG_AW-1:0] idRdIn,
    input  logic              idRegWriteIn,
    input  logic              idMemReadIn,
    input  logic              flushIn,
    output logic [2:0]        forward1Out,
    output logic [2:0]        forward2Out,
    output logic              stallOut,
    output logic              bubbleOut,
    output logic [CNT_W-1:0]  stallCntOut,
    output logic [CNT_W-1:0]  fwdCntOut
);

    // EX record; MEM only needs what a forward decision reads.
    logic              r_ex_valid;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_ex_rw;
    logic              r_ex_mr;
    logic              r_mem_valid;
    logic [REG_AW-1:0] r_mem_rd;
    logic              r_mem_rw;
    logic [2:0]        r_fwd [2];

    logic              w_ex_prod;
    logic              w_mem_prod;
    logic              w_hz;
    logic              w_adv;
    logic [REG_AW-1:0] w_rs  [2];
    logic [2:0]        w_sel [2];

    assign w_ex_prod  = r_ex_valid && r_ex_rw && (r_ex_rd != '0);
    assign w_mem_prod = r_mem_valid && r_mem_rw && (r_mem_rd != '0);

    assign w_hz = idValidIn && r_ex_valid && r_ex_mr && (r_ex_rd != '0) &&
                  ((r_ex_rd == idRs1In) || (r_ex_rd == idRs2In));

    assign stallOut  = w_hz && !flushIn;
    assign bubbleOut = w_hz || flushIn;
    assign w_adv     = idValidIn && !bubbleOut;

    assign w_rs[0] = idRs1In;
    assign w_rs[1] = idRs2In;

    // Youngest producer (EX, becoming MEM) wins over the older MEM one.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sel
            always_comb begin
                w_sel[gi] = 3'd0;
                if (w_ex_prod && (r_ex_rd == w_rs[gi]))
                    w_sel[gi] = 3'd2;
                else if (w_mem_prod && (r_mem_rd == w_rs[gi]))
                    w_sel[gi] = 3'd1;
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)
                    r_fwd[gi] <= 3'd0;
                else
                    r_fwd[gi] <= w_adv ? w_sel[gi] : 3'd0;
            end
        end
    endgenerate

    assign forward1Out = r_fwd[0];
    assign forward2Out = r_fwd[1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ex_valid  <= 1'b0;
            r_ex_rd     <= '0;
            r_ex_rw     <= 1'b0;
            r_ex_mr     <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_rd    <= '0;
            r_mem_rw    <= 1'b0;
        end else begin
            r_mem_valid <= r_ex_valid;
            r_mem_rd    <= r_ex_rd;
            r_mem_rw    <= r_ex_rw;
            if (w_adv) begin
                r_ex_valid <= 1'b1;
                r_ex_rd    <= idRdIn;
                r_ex_rw    <= idRegWriteIn;
                r_ex_mr    <= idMemReadIn;
            end else begin
                r_ex_valid <= 1'b0;
                r_ex_rd    <= '0;
                r_ex_rw    <= 1'b0;
                r_ex_mr    <= 1'b0;
            end
        end
    end

`ifdef FWD_STAT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_fwd_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (stallOut)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_adv && ((w_sel[0] != 3'd0) || (w_sel[1] != 3'd0)))
                r_fwd_cnt <= r_fwd_cnt + 1'b1;
        end
    end

    assign stallCntOut = r_stall_cnt;
    assign fwdCntOut   = r_fwd_cnt;
`else
    assign stallCntOut = '0;
    assign fwdCntOut   = '0;
`endif

endmodule
